// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int NUM_SRC        = 4;
  localparam int DISPATCH_WIDTH = 2;
  localparam int NUM_REGS       = 32;
  localparam int NUM_REGS_WIDTH = $clog2(NUM_REGS);
  localparam int REG_WIDTH      = 32;
  localparam int SRC_IDX_WIDTH  = $clog2(NUM_SRC);

  // One writeback request, or one write headed for a regfile port.
  typedef struct packed {
    logic                      valid;
    logic [NUM_REGS_WIDTH-1:0] rd;
    logic [REG_WIDTH-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_multi_pick.sv
// Round-robin multi-grant picker.
// - Scans the sources circularly, starting at the round-robin pointer.
// - Grants up to NPORT nonzero-rd requests and steers the k-th grant to port k.
// - A request whose rd matches an rd already granted this cycle is marked
//   conflicted, and the pointer is moved onto it so it goes first next cycle.
// - Once every port is taken the scan stops granting and stops marking conflicts.
module regfile_wb_arbiter_rr_multi_pick
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NSRC  = NUM_SRC,
  parameter int NPORT = DISPATCH_WIDTH,
  parameter int RDW   = NUM_REGS_WIDTH,
  parameter int IDXW  = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]             i_valid,
  input  logic [NSRC-1:0][RDW-1:0]    i_rd,
  input  logic [IDXW-1:0]             i_rrPtr,
  output logic [NSRC-1:0]             o_grant,
  output logic [NPORT-1:0]            o_portVld,
  output logic [NPORT-1:0][IDXW-1:0]  o_portIdx,
  output logic [IDXW-1:0]             o_nextPtr
);

  logic [NPORT-1:0][RDW-1:0] w_portRd;
  logic [IDXW-1:0]           w_idx;
  logic [IDXW-1:0]           w_firstConf;
  logic [IDXW-1:0]           w_lastGnt;
  logic                      w_anyConf;
  logic                      w_anyGnt;
  logic                      w_conflict;
  logic                      w_placed;

  // Circular scan from the pointer: grant, mark conflicts, and choose the next pointer.
  always_comb begin
    o_grant     = '0;
    o_portVld   = '0;
    o_portIdx   = '0;
    w_portRd    = '0;
    w_idx       = '0;
    w_firstConf = '0;
    w_lastGnt   = '0;
    w_anyConf   = 1'b0;
    w_anyGnt    = 1'b0;
    w_conflict  = 1'b0;
    w_placed    = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      w_idx      = IDXW'((32'(i_rrPtr) + 32'(j)) % NSRC);
      w_conflict = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        if (o_portVld[k] && (w_portRd[k] == i_rd[w_idx])) begin
          w_conflict = 1'b1;
        end
      end
      if (i_valid[w_idx] && (i_rd[w_idx] != '0) && !(&o_portVld)) begin
        if (w_conflict) begin
          if (!w_anyConf) begin
            w_anyConf   = 1'b1;
            w_firstConf = w_idx;
          end
        end else begin
          o_grant[w_idx] = 1'b1;
          w_anyGnt       = 1'b1;
          w_lastGnt      = w_idx;
          w_placed       = 1'b0;
          for (int k = 0; k < NPORT; k++) begin
            if (!w_placed && !o_portVld[k]) begin
              o_portVld[k] = 1'b1;
              o_portIdx[k] = w_idx;
              w_portRd[k]  = i_rd[w_idx];
              w_placed     = 1'b1;
            end
          end
        end
      end
    end
    if (w_anyConf) begin
      o_nextPtr = w_firstConf;
    end else if (w_anyGnt) begin
      o_nextPtr = IDXW'((32'(w_lastGnt) + 32'd1) % NSRC);
    end else begin
      o_nextPtr = i_rrPtr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges the writeback requesters onto the regfile write ports.
// - Writes to x0 are acknowledged at once and thrown away.
// - The port outputs are registered and drive the regfile write ports directly.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_SRC-1:0]                             src_valid,
  input  logic [NUM_SRC-1:0][NUM_REGS_WIDTH-1:0]         src_rd,
  input  logic [NUM_SRC-1:0][REG_WIDTH-1:0]              src_data,
  output logic [NUM_SRC-1:0]                             src_ready,
  output logic [DISPATCH_WIDTH-1:0][NUM_REGS_WIDTH-1:0]  addr_rd,
  output logic [DISPATCH_WIDTH-1:0][REG_WIDTH-1:0]       rd_data,
  output logic [DISPATCH_WIDTH-1:0]                      rd_wen
);

  logic [SRC_IDX_WIDTH-1:0]                      r_rrPtr;
  logic [SRC_IDX_WIDTH-1:0]                      w_nextPtr;
  logic [NUM_SRC-1:0]                            w_grant;
  logic [DISPATCH_WIDTH-1:0]                     w_portVld;
  logic [DISPATCH_WIDTH-1:0][SRC_IDX_WIDTH-1:0]  w_portIdx;
  wb_req_t [DISPATCH_WIDTH-1:0]                  w_portReq;

  regfile_wb_arbiter_rr_multi_pick #(
    .NSRC  (NUM_SRC),
    .NPORT (DISPATCH_WIDTH),
    .RDW   (NUM_REGS_WIDTH),
    .IDXW  (SRC_IDX_WIDTH)
  ) u_pick (
    .i_valid   (src_valid),
    .i_rd      (src_rd),
    .i_rrPtr   (r_rrPtr),
    .o_grant   (w_grant),
    .o_portVld (w_portVld),
    .o_portIdx (w_portIdx),
    .o_nextPtr (w_nextPtr)
  );

  // Accept granted requests and x0 writes; nothing is accepted while in reset.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !rst && src_valid[i] && ((src_rd[i] == '0) || w_grant[i]);
    end
  end

  // Gather the write for each port; unused ports carry zeros.
  always_comb begin
    w_portReq = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (w_portVld[k]) begin
        w_portReq[k].valid = 1'b1;
        w_portReq[k].rd    = src_rd[w_portIdx[k]];
        w_portReq[k].data  = src_data[w_portIdx[k]];
      end
    end
  end

  // Register the port outputs and advance the pointer; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wen  <= '0;
      addr_rd <= '0;
      rd_data <= '0;
      r_rrPtr <= '0;
    end else begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        rd_wen[k]  <= w_portReq[k].valid;
        addr_rd[k] <= w_portReq[k].rd;
        rd_data[k] <= w_portReq[k].data;
      end
      r_rrPtr <= w_nextPtr;
    end
  end

  // Two enabled ports must never target the same register in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < DISPATCH_WIDTH; a++) begin
        for (int b = a + 1; b < DISPATCH_WIDTH; b++) begin
          assert (!(rd_wen[a] && rd_wen[b] && (addr_rd[a] == addr_rd[b])))
            else $error("duplicate regfile write address on ports %0d and %0d", a, b);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change 1 time unit after a rising edge.
// src_ready is sampled 1 time unit after the inputs change.
// The registered port outputs are sampled 1 time unit after the next rising edge.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic                                          clk = 1'b0;
  logic                                          rst;
  logic [NUM_SRC-1:0]                            src_valid;
  logic [NUM_SRC-1:0][NUM_REGS_WIDTH-1:0]        src_rd;
  logic [NUM_SRC-1:0][REG_WIDTH-1:0]             src_data;
  logic [NUM_SRC-1:0]                            src_ready;
  logic [DISPATCH_WIDTH-1:0][NUM_REGS_WIDTH-1:0] addr_rd;
  logic [DISPATCH_WIDTH-1:0][REG_WIDTH-1:0]      rd_data;
  logic [DISPATCH_WIDTH-1:0]                     rd_wen;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0][4:0]  rdv;
  logic [3:0][31:0] dv;
  int               grantCnt [4];
  int               p0Src;
  int               p1Src;
  logic [31:0]      expD0;
  logic [31:0]      expD1;

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;
  localparam logic [31:0] DD = 32'hDDDD_0004;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .src_ready (src_ready),
    .addr_rd   (addr_rd),
    .rd_data   (rd_data),
    .rd_wen    (rd_wen)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0][4:0] rd, input logic [3:0][31:0] data);
    src_valid = valid;
    src_rd    = rd;
    src_data  = data;
    #1;
  endtask

  task automatic checkPorts(input string tag, input logic [1:0] wen,
                            input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1);
    checkOutput({tag, "_wen"}, 64'(rd_wen), 64'(wen));
    checkOutput({tag, "_addr0"}, 64'(addr_rd[0]), 64'(a0));
    checkOutput({tag, "_data0"}, 64'(rd_data[0]), 64'(d0));
    checkOutput({tag, "_addr1"}, 64'(addr_rd[1]), 64'(a1));
    checkOutput({tag, "_data1"}, 64'(rd_data[1]), 64'(d1));
  endtask

  // Directed test sequence.
  initial begin
    // Reset for two cycles, with every source requesting.
    rst = 1'b1;
    applyStimulus(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
    cycle();
    checkOutput("rst1_wen", 64'(rd_wen), 64'd0);
    checkOutput("rst1_ready", 64'(src_ready), 64'd0);
    cycle();
    checkOutput("rst2_wen", 64'(rd_wen), 64'd0);
    checkOutput("rst2_ready", 64'(src_ready), 64'd0);

    // Four requests arrive together; the pointer starts at 0.
    rst = 1'b0;
    applyStimulus(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
    checkOutput("all4_ready_t", 64'(src_ready), 64'b0011);
    cycle();
    checkPorts("all4_t1", 2'b11, 5'd1, DA, 5'd2, DB);
    applyStimulus(4'b1100, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
    checkOutput("all4_ready_t1", 64'(src_ready), 64'b1100);
    cycle();
    checkPorts("all4_t2", 2'b11, 5'd3, DC, 5'd4, DD);

    // A write to x0 uses no port.
    applyStimulus(4'b0011, {5'd0, 5'd0, 5'd7, 5'd0}, {32'd0, 32'd0, 32'h1234_5678, 32'hDEAD_BEEF});
    checkOutput("x0_ready", 64'(src_ready), 64'b0011);
    cycle();
    checkPorts("x0_ports", 2'b01, 5'd7, 32'h1234_5678, 5'd0, 32'd0);

    // With the pointer at 2, a lone grant from source 3 wraps the pointer to 0.
    applyStimulus(4'b1000, {5'd9, 5'd0, 5'd0, 5'd0}, {32'hEEEE_0009, 32'd0, 32'd0, 32'd0});
    checkOutput("wrap_ready", 64'(src_ready), 64'b1000);
    cycle();
    checkPorts("wrap_ports", 2'b01, 5'd9, 32'hEEEE_0009, 5'd0, 32'd0);

    // Sources 0 and 1 both target rd5: source 1 waits and the pointer moves to 1.
    applyStimulus(4'b0111, {5'd0, 5'd6, 5'd5, 5'd5}, {32'd0, 32'hF2F2_0002, 32'hF1F1_0001, 32'hF0F0_0000});
    checkOutput("conf_ready", 64'(src_ready), 64'b0101);
    cycle();
    checkPorts("conf_ports", 2'b11, 5'd5, 32'hF0F0_0000, 5'd6, 32'hF2F2_0002);
    // A pointer of 1 puts source 1 ahead of source 0 in the scan.
    applyStimulus(4'b0011, {5'd0, 5'd0, 5'd5, 5'd8}, {32'd0, 32'd0, 32'hF1F1_0001, 32'hF4F4_0004});
    checkOutput("conf2_ready", 64'(src_ready), 64'b0011);
    cycle();
    checkPorts("conf2_ports", 2'b11, 5'd5, 32'hF1F1_0001, 5'd8, 32'hF4F4_0004);

    // All sources stay valid for 40 cycles; the pointer starts at 1.
    for (int i = 0; i < 4; i++) grantCnt[i] = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 4; i++) begin
        rdv[i] = 5'(10 + i);
        dv[i]  = 32'h5000_0000 + 32'(i * 256) + 32'(grantCnt[i]);
      end
      applyStimulus(4'b1111, rdv, dv);
      checkOutput("fair_ready", 64'(src_ready), (c % 2 == 0) ? 64'b0110 : 64'b1001);
      p0Src = (c % 2 == 0) ? 1 : 3;
      p1Src = (c % 2 == 0) ? 2 : 0;
      expD0 = dv[p0Src];
      expD1 = dv[p1Src];
      cycle();
      checkPorts("fair_ports", 2'b11, 5'(10 + p0Src), expD0, 5'(10 + p1Src), expD1);
      checkOutput("fair_distinct", 64'(addr_rd[0] == addr_rd[1]), 64'd0);
      grantCnt[p0Src]++;
      grantCnt[p1Src]++;
    end
    for (int i = 0; i < 4; i++) checkOutput("fair_count", 64'(grantCnt[i]), 64'd20);

    // Reset the cycle after a grant: the registered write is dropped and the pointer returns to 0.
    applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'd0, 32'h6666_0003});
    checkOutput("rstmid_ready_t", 64'(src_ready), 64'b0001);
    cycle();
    checkPorts("rstmid_t1", 2'b01, 5'd3, 32'h6666_0003, 5'd0, 32'd0);
    rst = 1'b1;
    applyStimulus(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
    checkOutput("rstmid_ready_rst", 64'(src_ready), 64'd0);
    cycle();
    checkPorts("rstmid_t2", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rst = 1'b0;
    applyStimulus(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
    checkOutput("rstmid_ready_after", 64'(src_ready), 64'b0011);
    cycle();
    checkPorts("rstmid_after", 2'b11, 5'd1, DA, 5'd2, DB);
    applyStimulus(4'b0000, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
